// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the instruction fetch unit
package fetch_pkg;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  localparam logic [31:0] EBREAK_WORD = 32'h00100073;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with capture, squash-to-nop and valid-kill controls
module if_id_reg #(
  parameter int ADDR_W = 8,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              squash,
  input  logic              kill,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc <= '0;
      if_instr <= NOP_WORD;
      if_valid <= 1'b0;
    end else if (capture) begin
      if_pc <= pc_in;
      if_instr <= instr_in;
      if_valid <= 1'b1;
    end else if (squash) begin
      if_instr <= NOP_WORD;
      if_valid <= 1'b0;
    end else if (kill) begin
      if_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC/FSM owner driving a combinational ROM and filling the IF/ID register
module inst_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] LAST_PC = 8'h4C,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD,
  parameter logic [31:0] EBREAK_WORD = fetch_pkg::EBREAK_WORD,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instruction,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              halted,
  output logic              misaligned_err
);
  import fetch_pkg::*;
  // top word-aligned address; fetching it halts instead of wrapping the PC
  localparam logic [ADDR_W-1:0] PC_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic capture, squash, kill, mis_set;
  assign imem_addr = pc;
  assign halted = state == HALT;
  always_comb begin
    state_n = state;
    pc_n = pc;
    capture = 1'b0;
    squash = 1'b0;
    kill = 1'b0;
    mis_set = 1'b0;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] == 2'b00) begin
            pc_n = redirect_target;
            squash = 1'b1;
          end else begin
            mis_set = 1'b1;
            kill = 1'b1;
            state_n = HALT;
          end
        end else if (flush) begin
          squash = 1'b1;
        end else if (!stall) begin
          capture = 1'b1;
          if (pc == LAST_PC || imem_instruction == EBREAK_WORD || pc == PC_MAX)
            state_n = HALT;
          else
            pc_n = pc + ADDR_W'(PC_INC);
        end
      end
      default: kill = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      fetch_count <= '0;
      misaligned_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fetch_count <= fetch_count + CNT_W'(capture);
      misaligned_err <= misaligned_err | mis_set;
    end
  end
  if_id_reg #(.ADDR_W(ADDR_W), .NOP_WORD(NOP_WORD)) u_if_id (
    .clk(clk),
    .rst(reset),
    .capture(capture),
    .squash(squash),
    .kill(kill),
    .pc_in(pc),
    .instr_in(imem_instruction),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .if_valid(if_valid)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench with a ROM and a cycle-level reference model
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] EBRK = 32'h00100073;
  typedef struct {
    logic [7:0] a;
    logic [7:0] ipc;
    logic [31:0] ins;
    logic v;
    logic [15:0] c;
    logic h;
    logic m;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [7:0] redirect_target = '0;
  logic [7:0] imem_addr, if_pc;
  logic [31:0] imem_instruction, if_instr;
  logic if_valid, halted, misaligned_err;
  logic [15:0] fetch_count;
  logic [31:0] rom [64];
  exp_t sb [$];
  exp_t mon;
  int checks = 0, errors = 0;
  logic [7:0] m_pc = '0, m_ipc = '0;
  logic [31:0] m_ins = NOP;
  logic m_v = 1'b0, m_mis = 1'b0;
  logic [15:0] m_c = '0;
  int m_st = 0;
  always #5 clk = ~clk;
  assign imem_instruction = rom[imem_addr[7:2]];
  inst_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr(imem_addr),
    .imem_instruction(imem_instruction),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .if_valid(if_valid),
    .fetch_count(fetch_count),
    .halted(halted),
    .misaligned_err(misaligned_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rs, input logic st, input logic sl, input logic fl,
                     input logic rv, input logic [7:0] rt);
    exp_t e;
    logic [31:0] w;
    reset = rs;
    start = st;
    stall = sl;
    flush = fl;
    redirect_valid = rv;
    redirect_target = rt;
    if (rs) begin
      m_pc = '0; m_ipc = '0; m_ins = NOP; m_v = 0; m_c = '0; m_mis = 0; m_st = 0;
    end else if (m_st == 0) begin
      if (st) m_st = 1;
    end else if (m_st == 1) begin
      if (rv) begin
        if (rt[1:0] == 2'b00) begin
          m_pc = rt; m_v = 0; m_ins = NOP;
        end else begin
          m_mis = 1; m_st = 2; m_v = 0;
        end
      end else if (fl) begin
        m_v = 0; m_ins = NOP;
      end else if (!sl) begin
        w = rom[m_pc[7:2]];
        m_ins = w; m_ipc = m_pc; m_v = 1; m_c = m_c + 16'd1;
        if (m_pc == 8'h4C || w == EBRK || m_pc == 8'hFC) m_st = 2;
        else m_pc = m_pc + 8'd4;
      end
    end else begin
      m_v = 0;
    end
    e.a = m_pc; e.ipc = m_ipc; e.ins = m_ins; e.v = m_v; e.c = m_c;
    e.h = (m_st == 2); e.m = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      check("imem_addr", imem_addr, mon.a);
      check("if_pc", if_pc, mon.ipc);
      check("if_instr", if_instr, mon.ins);
      check("if_valid", if_valid, mon.v);
      check("fetch_count", fetch_count, mon.c);
      check("halted", halted, mon.h);
      check("misaligned_err", misaligned_err, mon.m);
    end
  end
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = NOP | (i << 7);
    rom[0] = 32'h00007033;
    rom[1] = 32'h00100093;
    rom[2] = 32'h00200113;
    rom[3] = 32'h00308193;
    rom[9] = 32'h404404b3;
    rom[19] = 32'h03002603;
    rom[32] = EBRK;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("rst_instr", if_instr, NOP);
    cyc(0, 0, 1, 1, 1, 8'h24);
    check("idle_ignores", imem_addr, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("start_nocap", if_valid, 1'b0);
    idle(3);
    check("run3_pc", if_pc, 8'h08);
    check("run3_instr", if_instr, 32'h00200113);
    check("run3_cnt", fetch_count, 16'd3);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("stall_addr", imem_addr, 8'h0C);
    check("stall_pc", if_pc, 8'h08);
    idle(1);
    check("unstall_instr", if_instr, 32'h00308193);
    cyc(0, 0, 0, 1, 0, 8'h00);
    check("flush_addr", imem_addr, 8'h10);
    cyc(0, 0, 1, 0, 1, 8'h24);
    check("redir_valid", if_valid, 1'b0);
    idle(1);
    check("redir_pc", if_pc, 8'h24);
    check("redir_instr", if_instr, 32'h404404b3);
    cyc(0, 0, 0, 0, 1, 8'h26);
    check("mis_err", misaligned_err, 1'b1);
    check("mis_addr", imem_addr, 8'h28);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    check("halt_hold", imem_addr, 8'h28);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 40 && m_st != 2; i++) idle(1);
    check("end_pc", if_pc, 8'h4C);
    check("end_instr", if_instr, 32'h03002603);
    check("end_cnt", fetch_count, 16'd20);
    check("end_halted", halted, 1'b1);
    idle(2);
    check("end_addr", imem_addr, 8'h4C);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(4);
    check("mid_addr", imem_addr, 8'h10);
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("mid_rst_cnt", fetch_count, 16'd0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    idle(1);
    check("restart_pc", if_pc, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h80);
    idle(2);
    check("ebreak_halt", halted, 1'b1);
    check("ebreak_addr", imem_addr, 8'h80);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'hF8);
    idle(3);
    check("top_addr", imem_addr, 8'hFC);
    check("top_halt", halted, 1'b1);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch initiator that pairs with the combinational instruction ROM: it owns the program counter, drives the ROM byte address, and captures the returned word into an IF/ID pipeline register. It handles start, stall, bubble (flush), branch/jump redirect, end-of-program detection and misaligned targets. Downstream, the decoder consumes if_instr/if_pc/if_valid.

Parameters:
ADDR_W, 8, byte-address width of PC and ROM address
RESET_PC, 8'h00, PC loaded on reset
LAST_PC, 8'h4C, address of final program word; fetching it ends the run
NOP_WORD, 32'h00000013, word placed in if_instr when squashed (addi x0,x0,0)
EBREAK_WORD, 32'h00100073, captured word that forces HALT
CNT_W, 16, fetch counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  leave IDLE and begin fetching
stall  in  1  hold PC and IF/ID register
flush  in  1  squash current fetch (bubble), PC holds
redirect_valid  in  1  taken branch/jump
redirect_target  in  ADDR_W  new PC
imem_addr  out  ADDR_W  byte address to ROM (= pc, combinational)
imem_instruction  in  32  ROM read data, valid same cycle
if_pc  out  ADDR_W  PC of captured word
if_instr  out  32  captured instruction
if_valid  out  1  if_instr is a real instruction
fetch_count  out  CNT_W  instructions captured with if_valid=1
halted  out  1  FSM in HALT
misaligned_err  out  1  sticky: redirect target[1:0] != 0

Behaviour:
- Reset (sync, highest priority, also mid-run): pc=RESET_PC, state=IDLE, if_pc=0, if_instr=NOP_WORD, if_valid=0, fetch_count=0, halted=0, misaligned_err=0.
- imem_addr = pc always; ROM is combinational, so capture happens at the edge ending the cycle in which pc is presented (1-cycle fetch latency).
- States: IDLE, RUN, HALT.
- IDLE: outputs held at reset values; start=1 -> RUN next edge (no capture that edge). Other inputs ignored.
- RUN, per edge, priority redirect > flush > stall > normal:
  - redirect_valid, target[1:0]==0: pc<=target; if_valid<=0; if_instr<=NOP_WORD; count unchanged.
  - redirect_valid, target[1:0]!=0: misaligned_err<=1; state<=HALT; pc unchanged; if_valid<=0.
  - flush: if_valid<=0, if_instr<=NOP_WORD, pc holds.
  - stall: pc, if_pc, if_instr, if_valid, count all hold.
  - normal: if_instr<=imem_instruction; if_pc<=pc; if_valid<=1; fetch_count<=fetch_count+1 (wraps at 2^CNT_W); pc<=pc+4.
  - Normal capture with pc==LAST_PC, or captured word==EBREAK_WORD, or pc==8'hFC: capture completes as above, pc holds (no wrap), state<=HALT.
- HALT: halted=1; pc holds; if_valid<=0 on first HALT edge and stays 0; all inputs except reset ignored; exit only by reset.
- start while RUN/HALT ignored. stall+redirect same edge: redirect wins.
- pc bits [1:0] are always 0 while in RUN.

Decomposition:
- Shared package fetch_pkg: NOP_WORD, EBREAK_WORD, fetch state enum (IDLE/RUN/HALT), PC_INC=4.
- One natural sub-module: if_id_reg (IF/ID pipeline register with hold/squash controls); PC and FSM live in the top.

Test Plan:
- Reset, start, 3 free-run cycles -> if_pc 0x00,0x04,0x08 with if_instr 0x00007033,0x00100093,0x00200113; if_valid=1; fetch_count=3.
- Stall held 2 cycles with if_pc=0x08 -> if_pc/if_instr/fetch_count unchanged, imem_addr stays 0x0C; release -> next capture 0x0C/0x00308193.
- Redirect to 0x24 with stall also asserted -> if_valid=0 for one edge, next capture if_pc=0x24, if_instr=0x404404b3.
- Redirect to 0x26 -> misaligned_err=1, halted=1 next edge, imem_addr unchanged, if_valid=0 thereafter.
- Free run from start to end -> last capture if_pc=0x4C, if_instr=0x03002603, fetch_count=20, halted=1, pc stays 0x4C.
- Reset asserted mid-run at pc=0x10 -> next edge all outputs at reset values, state IDLE; start again restarts from 0x00.
